// File: rtl/debounce_multi.sv
// debounce_multi: parametrised multi-channel debouncer.
// Each channel has a SYNC_STAGES-deep synchroniser feeding a saturating
// stability counter. The counter advances only on the tick sample enable.
// A channel's debounced output takes the new level only after STABLE_CYCLES
// consecutive ticks in which the synchronised input disagrees with it.
// Rising and falling edges are debounced in the same way.
// Configuration macro: DEBOUNCE_EDGE_EN. When it is defined, rise/fall are
// registered one-clock pulses. When it is not defined, rise/fall are tied
// to 0 and the edge registers are not built.
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                tick,
    input  logic [CHANNELS-1:0] inp,
    output logic [CHANNELS-1:0] outp,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  s;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_d;
    logic [CHANNELS-1:0]                  outp_q;
    logic [CHANNELS-1:0]                  outp_d;

    // Synchroniser chain: shifts on every clock, independent of tick.
    always_ff @(posedge clk or posedge clr) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clr) begin
            sync_q <= {SYNC_STAGES{INIT_VEC}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], inp};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state logic: count consecutive mismatching ticks and accept the new level on the last one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        outp_d = outp_q;
        if (tick) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (s[ch] == outp_q[ch]) begin
                    cnt_d[ch] = '0;
                end else if (cnt_q[ch] == CNT_LAST) begin
                    outp_d[ch] = s[ch];
                    cnt_d[ch]  = '0;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Stability counters and debounced levels. Reset discards any partial count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q  <= '0;
            outp_q <= INIT_VEC;
        end else begin
            cnt_q  <= cnt_d;
            outp_q <= outp_d;
        end
    end

    assign outp = outp_q;

`ifdef DEBOUNCE_EDGE_EN
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;

    // Edge pulses: registered together with outp, so each pulse lines up with the clock in which outp changes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= outp_d & ~outp_q;
            fall_q <= ~outp_d & outp_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel debouncer for mechanical inputs such as buttons and switches. It is the next generation of the three-tap AND-style debouncer.
- Each channel: SYNC_STAGES-deep synchroniser, then a saturating stability counter that runs on a sample-enable tick.
- A channel's output toggles only after STABLE_CYCLES consecutive ticks disagree with its current output.
- Both edges are debounced symmetrically, unlike the AND filter, which debounces only the rising edge.
- Sits between board pins and the counter/scan logic; also emits one-cycle rise/fall pulses.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
STABLE_CYCLES, 16, consecutive mismatching ticks required to accept a new level (>=1)
INIT_LEVEL, 0, reset value of synchroniser, debounced output and internal state (0 or 1, applied to all channels)

Ports:
clk  input  1  system clock; all flops on rising edge
clr  input  1  asynchronous, active-high reset
tick  input  1  sample enable; tie high to sample every clk
inp  input  CHANNELS  raw asynchronous inputs
outp  output  CHANNELS  debounced levels
rise  output  CHANNELS  one-clk pulse when outp goes 0->1
fall  output  CHANNELS  one-clk pulse when outp goes 1->0

Behaviour:
Reset (clr high, asynchronous):
- Sync flops and outp = INIT_LEVEL replicated; counters = 0; rise = fall = 0.
- Applies mid-count: a partial count is discarded and no pulse is emitted.

Synchroniser:
- Shifts every clk regardless of tick.
- s = last stage.

Per channel, evaluated on each clk edge with tick = 1:
- s == outp: counter <= 0.
- s != outp and counter < STABLE_CYCLES-1: counter <= counter+1.
- s != outp and counter == STABLE_CYCLES-1: outp <= s; counter <= 0; rise or fall <= 1 for that clk.
- tick = 0: counter and outp hold; rise/fall <= 0.

Pulses:
- rise/fall are registered and asserted exactly in the clk where outp changes.
- They are never asserted together on one channel.

Counter:
- Width = max(1, clog2(STABLE_CYCLES)).
- Never exceeds STABLE_CYCLES-1; no wrap-around.

Glitches:
- Any tick sample with s == outp restarts the count from 0.

Latency (tick held high, input steps before edge 1):
- s updates at edge SYNC_STAGES.
- outp flips at edge SYNC_STAGES+STABLE_CYCLES.

Channel independence:
- Channels are fully independent.
- Simultaneous transitions on several channels are handled in parallel, with identical latency.

Edge case:
- STABLE_CYCLES = 1: outp follows s on the first mismatching tick.

Optional Feature:
DEBOUNCE_EDGE_EN
- Defined: rise/fall logic and registers are built as described.
- Undefined: rise and fall are driven constant 0, the edge registers are removed, and outp behaviour is unchanged.
- Port list is identical in both builds.

Test Plan:
1. Reset: CHANNELS=4, INIT_LEVEL=0, clr pulse with inp=4'hF -> outp=0, rise=0, fall=0 during and immediately after clr.
2. Clean step: tick=1, STABLE_CYCLES=16, SYNC_STAGES=2, inp[0] 0->1 before edge 1 -> outp[0]=1 at edge 18, rise[0]=1 for exactly that one clk, other channels unchanged.
3. Glitch reject: inp[1] high for 10 clks then low, repeated 5 times -> outp[1] stays 0, no rise/fall pulses.
4. Tick gating: tick high every 4th clk, inp[2] steps 1->0 from outp=1 -> outp[2] falls after the 16th mismatching tick, fall[2] is a single clk pulse, counter holds between ticks.
5. Reset mid-count: inp[3] held high 10 clks, clr pulsed, inp held -> outp[3] rises 18 clks after clr release, not earlier.
6. Build without DEBOUNCE_EDGE_EN, rerun test 2 -> outp timing identical, rise=fall=0 throughout.
